// File: rtl/flatten_seq_pkg.sv
// Shared definitions for the flatten-stage sequencer.
// Holds the frame geometry (64 columns x 16 rows = 1024 elements),
// the address widths derived from it, the FSM state encoding, and the two
// address-mapping helpers used by the transpose.
package flatten_seq_pkg;

  localparam int NCOL   = 64;   // source columns, transpose outer index
  localparam int NROW   = 16;   // source rows, transpose inner index
  localparam int NWORDS = 128;  // eight-lane pool words per frame

  localparam int COL_W  = 6;    // log2(NCOL)
  localparam int ROW_W  = 4;    // log2(NROW)
  localparam int ELEM_W = 10;   // log2(NCOL*NROW)
  localparam int WORD_W = 7;    // log2(NWORDS)
  localparam int FC_W   = 5;    // 32-lane FC words in the FC-input buffer

  localparam logic [COL_W-1:0]  COL_MAX  = 6'd63;
  localparam logic [ROW_W-1:0]  ROW_MAX  = 4'd15;
  localparam logic [WORD_W-1:0] WORD_MAX = 7'd127;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FULL  = 3'd2,
    ST_TRANS = 3'd3,
    ST_DRAIN = 3'd4,
    ST_READY = 3'd5
  } state_t;

  // Source element address col + row*NCOL; NCOL is a power of two, so this
  // is a plain concatenation.
  function automatic logic [ELEM_W-1:0] src_elem_addr(input logic [COL_W-1:0] col,
                                                      input logic [ROW_W-1:0] row);
    return {row, col};
  endfunction

  // Sequential FC-input index col*NROW + row, i.e. the issue number k.
  function automatic logic [ELEM_W-1:0] dst_elem_addr(input logic [COL_W-1:0] col,
                                                      input logic [ROW_W-1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/flatten_seq_if.sv
// Bus bundle for the flatten sequencer: pool-word capture, source buffer
// read port, FC-input buffer write/read ports, FC1 request and the
// start/done/status handshake.
//  slave  : the sequencer side (takes clear/pool_wr_vld/start/fc_rd_req/fc_rd_addr)
//  master : the surrounding datapath/controller side
interface flatten_seq_if;
  import flatten_seq_pkg::*;

  logic              clear;
  logic              pool_wr_vld;
  logic              src_wr_en;
  logic [WORD_W-1:0] src_wr_addr;
  logic              start;
  logic              src_rd_en;
  logic [ELEM_W-1:0] src_rd_addr;
  logic              dst_wr_en;
  logic [ELEM_W-1:0] dst_wr_addr;
  logic              fc_rd_req;
  logic [FC_W-1:0]   fc_rd_addr;
  logic              dst_rd_en;
  logic [FC_W-1:0]   dst_rd_addr;
  logic              fc_rd_vld;
  logic              busy;
  logic              done;
  logic              ovf_err;

  modport slave (
    input  clear, pool_wr_vld, start, fc_rd_req, fc_rd_addr,
    output src_wr_en, src_wr_addr, src_rd_en, src_rd_addr,
           dst_wr_en, dst_wr_addr, dst_rd_en, dst_rd_addr,
           fc_rd_vld, busy, done, ovf_err
  );

  modport master (
    output clear, pool_wr_vld, start, fc_rd_req, fc_rd_addr,
    input  src_wr_en, src_wr_addr, src_rd_en, src_rd_addr,
           dst_wr_en, dst_wr_addr, dst_rd_en, dst_rd_addr,
           fc_rd_vld, busy, done, ovf_err
  );

endinterface

// File: rtl/flatten_seq_addr_gen.sv
// Transpose address generator.
// Steps a row counter (inner, 0..NROW-1) and a column counter (outer,
// 0..NCOL-1) once per issue cycle with no bubble at column boundaries.
//  clk, rst_n   : clock, asynchronous active-low reset
//  clear        : synchronous return of both counters to 0
//  step         : advance one issue this cycle
//  src_rd_addr  : col + row*NCOL for the current issue
//  elem_idx     : sequential issue number col*NROW + row
//  last         : current issue is the final element of the frame
module flatten_seq_addr_gen
  import flatten_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  output logic [ELEM_W-1:0] src_rd_addr,
  output logic [ELEM_W-1:0] elem_idx,
  output logic              last
);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;

  // Row/column counters: row wraps and column advances in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= 4'd0;
      col_r <= 6'd0;
    end else if (clear) begin
      row_r <= 4'd0;
      col_r <= 6'd0;
    end else if (step) begin
      if (row_r == ROW_MAX) begin
        row_r <= 4'd0;
        col_r <= (col_r == COL_MAX) ? 6'd0 : col_r + 6'd1;
      end else begin
        row_r <= row_r + 4'd1;
      end
    end
  end

  assign src_rd_addr = src_elem_addr(col_r, row_r);
  assign elem_idx    = dst_elem_addr(col_r, row_r);
  assign last        = step && (row_r == ROW_MAX) && (col_r == COL_MAX);

endmodule

// File: rtl/flatten_seq.sv
// Flatten-stage sequencer between the last pooling layer and FC1.
// Captures NWORDS pool words into the source buffer, runs the column-major
// transpose into the FC-input buffer, then grants FC1 reads of that buffer.
//  clk, rst_n : clock, asynchronous active-low reset
//  RD_LAT     : source buffer read latency (1..3)
//  bus        : flatten_seq_if.slave
//               clear       sync abort, back to IDLE, drops ovf_err
//               pool_wr_vld -> src_wr_en/src_wr_addr (same-cycle accept)
//               start       -> src_rd_en/src_rd_addr issue stream
//               dst_wr_en/dst_wr_addr: issue stream delayed by RD_LAT
//               fc_rd_req/fc_rd_addr -> dst_rd_en/dst_rd_addr, fc_rd_vld next cycle
//               busy (TRANS/DRAIN), done (pulse on READY entry), ovf_err (sticky)
module flatten_seq
  import flatten_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  flatten_seq_if.slave bus
);

  state_t            state_r;
  logic [WORD_W-1:0] fill_cnt_r;
  logic [1:0]        drain_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              ovf_err_r;
  logic              fc_rd_vld_r;

  // Delay line carrying each issue's enable and sequential index to the
  // FC-input write port; stage RD_LAT-1 drives the buffer.
  logic [RD_LAT-1:0] dly_en_r;
  logic [ELEM_W-1:0] dly_addr_r [RD_LAT];

  logic              fill_ok_s;
  logic              wr_acc_s;
  logic              rd_grant_s;
  logic              step_s;
  logic              last_s;
  logic [ELEM_W-1:0] src_addr_s;
  logic [ELEM_W-1:0] elem_idx_s;

  // Acceptance and grant qualifiers; clear overrides every request.
  always_comb begin
    fill_ok_s  = (state_r == ST_IDLE) || (state_r == ST_FILL);
    // rst_n gate keeps the write enable low while reset is held
    wr_acc_s   = rst_n && !bus.clear && bus.pool_wr_vld && fill_ok_s;
    rd_grant_s = !bus.clear && bus.fc_rd_req && (state_r == ST_READY);
    step_s     = (state_r == ST_TRANS);
  end

  flatten_seq_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (bus.clear),
    .step        (step_s),
    .src_rd_addr (src_addr_s),
    .elem_idx    (elem_idx_s),
    .last        (last_s)
  );

  // Main FSM with fill/drain counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      fill_cnt_r  <= 7'd0;
      drain_cnt_r <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_err_r   <= 1'b0;
      fc_rd_vld_r <= 1'b0;
    end else if (bus.clear) begin
      state_r     <= ST_IDLE;
      fill_cnt_r  <= 7'd0;
      drain_cnt_r <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_err_r   <= 1'b0;
      fc_rd_vld_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      fc_rd_vld_r <= rd_grant_s;
      if (bus.pool_wr_vld && !fill_ok_s) begin
        ovf_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (wr_acc_s) begin
            fill_cnt_r <= 7'd1;
            state_r    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (wr_acc_s) begin
            if (fill_cnt_r == WORD_MAX) begin
              fill_cnt_r <= 7'd0;
              state_r    <= ST_FULL;
            end else begin
              fill_cnt_r <= fill_cnt_r + 7'd1;
            end
          end
        end
        ST_FULL: begin
          if (bus.start) begin
            busy_r  <= 1'b1;
            state_r <= ST_TRANS;
          end
        end
        ST_TRANS: begin
          if (last_s) begin
            drain_cnt_r <= 2'd0;
            state_r     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // wait out the read latency so the final element is written
          if (drain_cnt_r == 2'(RD_LAT - 1)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_READY;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-latency delay line; clear flushes in-flight writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_en_r <= '0;
      for (int i = 0; i < RD_LAT; i++) dly_addr_r[i] <= 10'd0;
    end else if (bus.clear) begin
      dly_en_r <= '0;
      for (int i = 0; i < RD_LAT; i++) dly_addr_r[i] <= 10'd0;
    end else begin
      dly_en_r[0]   <= step_s;
      dly_addr_r[0] <= elem_idx_s;
      for (int i = 1; i < RD_LAT; i++) begin
        dly_en_r[i]   <= dly_en_r[i-1];
        dly_addr_r[i] <= dly_addr_r[i-1];
      end
    end
  end

  assign bus.src_wr_en   = wr_acc_s;
  assign bus.src_wr_addr = fill_cnt_r;
  assign bus.src_rd_en   = step_s;
  assign bus.src_rd_addr = src_addr_s;
  assign bus.dst_wr_en   = dly_en_r[RD_LAT-1];
  assign bus.dst_wr_addr = dly_addr_r[RD_LAT-1];
  assign bus.dst_rd_en   = rd_grant_s;
  assign bus.dst_rd_addr = rd_grant_s ? bus.fc_rd_addr : 5'd0;
  assign bus.fc_rd_vld   = fc_rd_vld_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.ovf_err     = ovf_err_r;

endmodule

// File: tb/tb_flatten_seq.sv
// Self-checking bench for flatten_seq. Two instances (RD_LAT=1 and RD_LAT=3)
// share one stimulus stream; expected writes/reads/done pulses are queued as
// stimulus is driven and popped when the DUTs produce them.
module tb_flatten_seq;
  import flatten_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       pool_wr_vld = 1'b0;
  logic       start = 1'b0;
  logic       fc_rd_req = 1'b0;
  logic [4:0] fc_rd_addr = 5'd0;

  flatten_seq_if bus1();
  flatten_seq_if bus3();

  assign bus1.clear = clear;       assign bus3.clear = clear;
  assign bus1.pool_wr_vld = pool_wr_vld; assign bus3.pool_wr_vld = pool_wr_vld;
  assign bus1.start = start;       assign bus3.start = start;
  assign bus1.fc_rd_req = fc_rd_req; assign bus3.fc_rd_req = fc_rd_req;
  assign bus1.fc_rd_addr = fc_rd_addr; assign bus3.fc_rd_addr = fc_rd_addr;

  flatten_seq #(.RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  flatten_seq #(.RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  always #5 clk = ~clk;

  wire [39:0] outs1 = {bus1.src_wr_en, bus1.src_wr_addr, bus1.src_rd_en, bus1.src_rd_addr,
                       bus1.dst_wr_en, bus1.dst_wr_addr, bus1.dst_rd_en, bus1.dst_rd_addr,
                       bus1.fc_rd_vld, bus1.busy, bus1.done, bus1.ovf_err};
  wire [39:0] outs3 = {bus3.src_wr_en, bus3.src_wr_addr, bus3.src_rd_en, bus3.src_rd_addr,
                       bus3.dst_wr_en, bus3.dst_wr_addr, bus3.dst_rd_en, bus3.dst_rd_addr,
                       bus3.fc_rd_vld, bus3.busy, bus3.done, bus3.ovf_err};

  typedef struct {int val; int due;} exp_t;
  exp_t q_wr[$], q_src[$], q_dst1[$], q_dst3[$], q_rd[$], q_vld[$];
  int   q_done1[$], q_done3[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // scoreboard: pop and compare whatever the DUTs produce this cycle
  task automatic monitor();
    exp_t e;
    int   d;
    if (bus1.src_wr_en || bus3.src_wr_en) begin
      total++;
      if (q_wr.size() == 0) begin
        bad++; $display("FAIL src_wr unexpected: cyc=%0d en1=%0b en3=%0b required none", cyc, bus1.src_wr_en, bus3.src_wr_en);
      end else begin
        e = q_wr.pop_front();
        if ({bus1.src_wr_en, bus3.src_wr_en} !== 2'b11 || bus1.src_wr_addr !== 7'(e.val) ||
            bus3.src_wr_addr !== 7'(e.val) || cyc != e.due) begin
          bad++; $display("FAIL src_wr: cyc=%0d addr1=%0d addr3=%0d required cyc=%0d addr=%0d", cyc, bus1.src_wr_addr, bus3.src_wr_addr, e.due, e.val);
        end
      end
    end
    if (bus1.src_rd_en || bus3.src_rd_en) begin
      total++;
      if (q_src.size() == 0) begin
        bad++; $display("FAIL src_rd unexpected: cyc=%0d en1=%0b en3=%0b required none", cyc, bus1.src_rd_en, bus3.src_rd_en);
      end else begin
        e = q_src.pop_front();
        if ({bus1.src_rd_en, bus3.src_rd_en} !== 2'b11 || bus1.src_rd_addr !== 10'(e.val) ||
            bus3.src_rd_addr !== 10'(e.val) || cyc != e.due) begin
          bad++; $display("FAIL src_rd: cyc=%0d addr1=%0d addr3=%0d required cyc=%0d addr=%0d", cyc, bus1.src_rd_addr, bus3.src_rd_addr, e.due, e.val);
        end
      end
    end
    if (bus1.dst_wr_en) begin
      total++;
      if (q_dst1.size() == 0) begin
        bad++; $display("FAIL dst_wr1 unexpected: cyc=%0d addr=%0d required none", cyc, bus1.dst_wr_addr);
      end else begin
        e = q_dst1.pop_front();
        if (bus1.dst_wr_addr !== 10'(e.val) || cyc != e.due) begin
          bad++; $display("FAIL dst_wr1: cyc=%0d addr=%0d required cyc=%0d addr=%0d", cyc, bus1.dst_wr_addr, e.due, e.val);
        end
      end
    end
    if (bus3.dst_wr_en) begin
      total++;
      if (q_dst3.size() == 0) begin
        bad++; $display("FAIL dst_wr3 unexpected: cyc=%0d addr=%0d required none", cyc, bus3.dst_wr_addr);
      end else begin
        e = q_dst3.pop_front();
        if (bus3.dst_wr_addr !== 10'(e.val) || cyc != e.due) begin
          bad++; $display("FAIL dst_wr3: cyc=%0d addr=%0d required cyc=%0d addr=%0d", cyc, bus3.dst_wr_addr, e.due, e.val);
        end
      end
    end
    if (bus1.dst_rd_en || bus3.dst_rd_en) begin
      total++;
      if (q_rd.size() == 0) begin
        bad++; $display("FAIL dst_rd unexpected: cyc=%0d en1=%0b en3=%0b required none", cyc, bus1.dst_rd_en, bus3.dst_rd_en);
      end else begin
        e = q_rd.pop_front();
        if ({bus1.dst_rd_en, bus3.dst_rd_en} !== 2'b11 || bus1.dst_rd_addr !== 5'(e.val) ||
            bus3.dst_rd_addr !== 5'(e.val) || cyc != e.due) begin
          bad++; $display("FAIL dst_rd: cyc=%0d addr1=%0d addr3=%0d required cyc=%0d addr=%0d", cyc, bus1.dst_rd_addr, bus3.dst_rd_addr, e.due, e.val);
        end
      end
    end
    if (bus1.fc_rd_vld || bus3.fc_rd_vld) begin
      total++;
      if (q_vld.size() == 0) begin
        bad++; $display("FAIL fc_rd_vld unexpected: cyc=%0d vld1=%0b vld3=%0b required none", cyc, bus1.fc_rd_vld, bus3.fc_rd_vld);
      end else begin
        e = q_vld.pop_front();
        if ({bus1.fc_rd_vld, bus3.fc_rd_vld} !== 2'b11 || cyc != e.due) begin
          bad++; $display("FAIL fc_rd_vld: cyc=%0d vld=%b%b required cyc=%0d both 1", cyc, bus1.fc_rd_vld, bus3.fc_rd_vld, e.due);
        end
      end
    end
    if (bus1.done) begin
      total++;
      if (q_done1.size() == 0) begin
        bad++; $display("FAIL done1 unexpected: cyc=%0d required no pulse", cyc);
      end else begin
        d = q_done1.pop_front();
        if (cyc != d) begin bad++; $display("FAIL done1: cyc=%0d required cyc=%0d", cyc, d); end
      end
    end
    if (bus3.done) begin
      total++;
      if (q_done3.size() == 0) begin
        bad++; $display("FAIL done3 unexpected: cyc=%0d required no pulse", cyc);
      end else begin
        d = q_done3.pop_front();
        if (cyc != d) begin bad++; $display("FAIL done3: cyc=%0d required cyc=%0d", cyc, d); end
      end
    end
  endtask

  // one clock: check at the falling edge, new inputs 1 time unit after the rising edge
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic int pending();
    return q_wr.size() + q_src.size() + q_dst1.size() + q_dst3.size() +
           q_rd.size() + q_vld.size() + q_done1.size() + q_done3.size();
  endfunction

  task automatic flush_queues();
    q_wr.delete(); q_src.delete(); q_dst1.delete(); q_dst3.delete();
    q_rd.delete(); q_vld.delete(); q_done1.delete(); q_done3.delete();
  endtask

  task automatic fill_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      pool_wr_vld = 1'b1;
      q_wr.push_back('{val: base + i, due: cyc});
      cycle();
    end
    pool_wr_vld = 1'b0;
  endtask

  // t0: first TRANS cycle; n_issue reads expected; with_done=0 means the
  // transpose is cut by clear during issue n_issue-1
  task automatic push_transpose(input int t0, input int n_issue, input bit with_done);
    for (int k = 0; k < n_issue; k++) begin
      q_src.push_back('{val: (k % 16) * 64 + k / 16, due: t0 + k});
      if (with_done || k + 1 <= n_issue - 1) q_dst1.push_back('{val: k, due: t0 + k + 1});
      if (with_done || k + 3 <= n_issue - 1) q_dst3.push_back('{val: k, due: t0 + k + 3});
    end
    if (with_done) begin
      q_done1.push_back(t0 + 1024 + 1);
      q_done3.push_back(t0 + 1024 + 3);
    end
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (pending() != 0) begin
      bad++; $display("FAIL drain_timeout: %0d expected events still pending after %0d cycles, required 0", pending(), budget);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (outs1 !== 40'd0 || outs3 !== 40'd0) begin
      bad++; $display("FAIL reset_outs: outs1=%h outs3=%h required 0", outs1, outs3);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    total++;
    if (outs1 !== 40'd0 || outs3 !== 40'd0) begin
      bad++; $display("FAIL post_reset_outs: outs1=%h outs3=%h required 0", outs1, outs3);
    end
  endtask

  task automatic test_transpose();
    fill_words(128, 0);
    total++;
    if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      bad++; $display("FAIL full_busy: busy=%b%b required 00", bus1.busy, bus3.busy);
    end
    start = 1'b1;
    push_transpose(cyc + 1, 1024, 1'b1);
    cycle();
    start = 1'b0;
    total++;
    if (bus1.busy !== 1'b1 || bus3.busy !== 1'b1) begin
      bad++; $display("FAIL trans_busy: busy=%b%b required 11", bus1.busy, bus3.busy);
    end
    run_drain(1200);
    repeat (5) cycle();
    total++;
    if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      bad++; $display("FAIL ready_busy: busy=%b%b required 00", bus1.busy, bus3.busy);
    end
  endtask

  task automatic test_fc_read();
    for (int i = 0; i < 5; i++) begin
      fc_rd_req  = 1'b1;
      fc_rd_addr = 5'(i);
      q_rd.push_back('{val: i, due: cyc});
      q_vld.push_back('{val: i, due: cyc + 1});
      cycle();
    end
    fc_rd_req = 1'b0;
    run_drain(20);
  endtask

  task automatic test_ovf();
    pool_wr_vld = 1'b1;
    cycle();
    pool_wr_vld = 1'b0;
    cycle();
    total++;
    if (bus1.ovf_err !== 1'b1 || bus3.ovf_err !== 1'b1) begin
      bad++; $display("FAIL ovf_set: ovf=%b%b required 11", bus1.ovf_err, bus3.ovf_err);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    total++;
    if (bus1.ovf_err !== 1'b0 || bus3.ovf_err !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: ovf=%b%b required 00", bus1.ovf_err, bus3.ovf_err);
    end
  endtask

  task automatic test_clear_mid();
    fill_words(128, 0);
    start = 1'b1;
    push_transpose(cyc + 1, 501, 1'b0);
    cycle();
    start = 1'b0;
    repeat (500) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (10) cycle();
    total++;
    if (pending() != 0 || bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      bad++; $display("FAIL clear_mid: pending=%0d busy=%b%b required 0 and 00", pending(), bus1.busy, bus3.busy);
    end
  endtask

  task automatic test_early_start();
    fill_words(100, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    total++;
    if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      bad++; $display("FAIL early_start_busy: busy=%b%b required 00", bus1.busy, bus3.busy);
    end
    fill_words(28, 100);
    start = 1'b1;
    push_transpose(cyc + 1, 1024, 1'b1);
    cycle();
    start = 1'b0;
    fc_rd_req  = 1'b1;
    fc_rd_addr = 5'd7;
    repeat (4) cycle();
    fc_rd_req = 1'b0;
    total++;
    if (bus1.busy !== 1'b1 || bus3.busy !== 1'b1) begin
      bad++; $display("FAIL late_start_busy: busy=%b%b required 11", bus1.busy, bus3.busy);
    end
    run_drain(1200);
    repeat (3) cycle();
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    fill_words(128, 0);
    start = 1'b1;
    push_transpose(cyc + 1, 1024, 1'b1);
    cycle();
    start = 1'b0;
    repeat (200) cycle();
    rst_n = 1'b0;
    #2;
    total++;
    if (outs1 !== 40'd0 || outs3 !== 40'd0) begin
      bad++; $display("FAIL async_reset_outs: outs1=%h outs3=%h required 0", outs1, outs3);
    end
    flush_queues();
    cycle();
    rst_n = 1'b1;
    repeat (1100) cycle();
    total++;
    if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
      bad++; $display("FAIL after_reset_busy: busy=%b%b required 00", bus1.busy, bus3.busy);
    end
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_fc_read();
    test_ovf();
    test_clear_mid();
    test_early_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
